// File: rtl/pipeline_run_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_run_ctl_pkg
// Description : Shared state encodings for the pipeline run/halt sequencer,
//               used by the sequencer and by anything decoding o_state.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_run_ctl_pkg;

    localparam logic [1:0] ST_HALT    = 2'b00;
    localparam logic [1:0] ST_RUN     = 2'b01;
    localparam logic [1:0] ST_STEP    = 2'b10;
    localparam logic [1:0] ST_BP_HALT = 2'b11;

endpackage
`default_nettype wire

// File: rtl/pipeline_run_ctl_btn.sv
`default_nettype none
// ============================================================================
// Module      : btn_conditioner
// Description : Raw push-button to single-cycle press pulse: 2-FF synchroniser,
//               stability debouncer and rising-edge pulse on the debounced level.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
    parameter int DB_CYCLES = 250000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int                 c_CNT_W    = $clog2(DB_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_d;
    logic               r_press;
    logic [c_CNT_W-1:0] r_stab_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_level    <= 1'b0;
            r_level_d  <= 1'b0;
            r_press    <= 1'b0;
            r_stab_cnt <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            // Any sample agreeing with the accepted level restarts the stability window
            if (r_sync2 == r_level) begin
                r_stab_cnt <= '0;
            end else if (r_stab_cnt == c_CNT_LAST) begin
                r_level    <= r_sync2;
                r_stab_cnt <= '0;
            end else begin
                r_stab_cnt <= r_stab_cnt + c_CNT_W'(1);
            end
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/pipeline_run_ctl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_run_ctl
// Description : Run/halt/single-step sequencer driving the Data_Path clock
//               enable, with PC breakpoint and enabled-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_run_ctl
    import pipeline_run_ctl_pkg::*;
#(
    parameter int DB_CYCLES = 250000,
    parameter int STEP_LEN  = 1,
    parameter int CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_btn_run,
    input  logic             i_btn_step,
    input  logic             i_bp_en,
    input  logic [31:0]      i_bp_addr,
    input  logic [31:0]      i_pc_f,
    output logic             o_clk_en,
    output logic [1:0]       o_state,
    output logic             o_bp_hit,
    output logic [CNT_W-1:0] o_cycle_cnt
);

    localparam int                  c_STEP_W    = (STEP_LEN > 1) ? $clog2(STEP_LEN) : 1;
    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP_LEN - 1);

    logic                w_run_press;
    logic                w_step_press;
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                w_bp_exit;
    logic [c_STEP_W-1:0] r_step_cnt;
    logic                r_armed;
    logic                w_bp_match;
    logic                w_clk_en;
    logic [CNT_W-1:0]    r_cycle_cnt;

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_run (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn_run),
        .o_press (w_run_press)
    );

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_step (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn_step),
        .o_press (w_step_press)
    );

    assign w_bp_match = i_bp_en && r_armed && (i_pc_f == i_bp_addr);
    assign w_clk_en   = ((r_state == ST_RUN) && !w_bp_match) || (r_state == ST_STEP);

    always_comb begin
        w_state_nxt = r_state;
        w_bp_exit   = 1'b0;
        case (r_state)
            ST_HALT: begin
                if (w_run_press)       w_state_nxt = ST_RUN;
                else if (w_step_press) w_state_nxt = ST_STEP;
            end
            ST_RUN: begin
                if (w_bp_match)        w_state_nxt = ST_BP_HALT;
                else if (w_run_press)  w_state_nxt = ST_HALT;
            end
            ST_STEP: begin
                if (r_step_cnt == c_STEP_LAST) w_state_nxt = ST_HALT;
            end
            ST_BP_HALT: begin
                if (w_run_press) begin
                    w_state_nxt = ST_RUN;
                    w_bp_exit   = 1'b1;
                end else if (w_step_press) begin
                    w_state_nxt = ST_STEP;
                    w_bp_exit   = 1'b1;
                end
            end
            default: w_state_nxt = ST_HALT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_HALT;
            r_step_cnt  <= '0;
            r_armed     <= 1'b1;
            r_cycle_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_STEP) && (w_state_nxt == ST_STEP))
                r_step_cnt <= r_step_cnt + c_STEP_W'(1);
            else
                r_step_cnt <= '0;
            // Leaving a breakpoint disarms it until the PC moves off the address,
            // so a stall holding the PC there cannot re-trigger the halt
            if (w_bp_exit)
                r_armed <= 1'b0;
            else if (i_pc_f != i_bp_addr)
                r_armed <= 1'b1;
            if (w_clk_en)
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end
    end

    assign o_clk_en    = w_clk_en;
    assign o_state     = r_state;
    assign o_bp_hit    = (r_state == ST_BP_HALT);
    assign o_cycle_cnt = r_cycle_cnt;

endmodule
`default_nettype wire
